// File: rtl/adc_ring_writer.sv
// Shares the RAM's write-only ADC port between the EMG and ECG capture channels,
// each writing a circular buffer. Define ADC_RING_TAG_EN to tag adc_dataIn[31:28].
module adc_ring_writer #(
    parameter logic [11:0] EMG_BASE = 12'hC00,
    parameter logic [11:0] ECG_BASE = 12'hE00,
    parameter int          DEPTH    = 64,
    parameter int          PTR_W    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic             emg_valid,
    input  logic [31:0]      emg_data,
    input  logic             ecg_valid,
    input  logic [31:0]      ecg_data,
    output logic             adc_wEn,
    output logic [11:0]      adc_addr,
    output logic [31:0]      adc_dataIn,
    output logic [PTR_W-1:0] emg_wptr,
    output logic [PTR_W-1:0] ecg_wptr,
    output logic             emg_wrap,
    output logic             ecg_wrap,
    output logic [7:0]       emg_ovr,
    output logic [7:0]       ecg_ovr
);

    logic        emg_pend, ecg_pend;
    logic [31:0] emg_hold, ecg_hold;
    logic        last_ecg;

    logic        emg_cap, ecg_cap;
    logic        gnt_emg, gnt_ecg, gnt_any;
    logic        emg_ovr_ev, ecg_ovr_ev;
    logic        emg_wrap_ev, ecg_wrap_ev;
    logic [11:0] emg_off, ecg_off;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    always_comb begin
        emg_cap     = enable & emg_valid;
        ecg_cap     = enable & ecg_valid;
        // Only flags registered before this edge compete; ties go away from last_ecg.
        gnt_emg     = emg_pend & (~ecg_pend | last_ecg);
        gnt_ecg     = ecg_pend & (~emg_pend | ~last_ecg);
        gnt_any     = gnt_emg | gnt_ecg;
        emg_ovr_ev  = emg_cap & emg_pend & ~gnt_emg;
        ecg_ovr_ev  = ecg_cap & ecg_pend & ~gnt_ecg;
        emg_wrap_ev = gnt_emg & (emg_wptr == PTR_W'(DEPTH - 1));
        ecg_wrap_ev = gnt_ecg & (ecg_wptr == PTR_W'(DEPTH - 1));
        emg_off     = 12'(emg_wptr);
        ecg_off     = 12'(ecg_wptr);
        wr_addr     = gnt_emg ? (EMG_BASE + emg_off) : (ECG_BASE + ecg_off);
`ifdef ADC_RING_TAG_EN
        wr_data     = gnt_emg ? {1'b0, emg_off[2:0], emg_hold[27:0]}
                              : {1'b1, ecg_off[2:0], ecg_hold[27:0]};
`else
        wr_data     = gnt_emg ? emg_hold : ecg_hold;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            emg_pend   <= 1'b0;
            ecg_pend   <= 1'b0;
            emg_hold   <= '0;
            ecg_hold   <= '0;
            last_ecg   <= 1'b1;
            adc_wEn    <= 1'b0;
            adc_addr   <= '0;
            adc_dataIn <= '0;
            emg_wptr   <= '0;
            ecg_wptr   <= '0;
            emg_wrap   <= 1'b0;
            ecg_wrap   <= 1'b0;
            emg_ovr    <= '0;
            ecg_ovr    <= '0;
        end else begin
            // A strobe on the grant edge re-arms pending with the new sample.
            if (emg_cap) begin
                emg_hold <= emg_data;
                emg_pend <= 1'b1;
            end else if (gnt_emg) begin
                emg_pend <= 1'b0;
            end
            if (ecg_cap) begin
                ecg_hold <= ecg_data;
                ecg_pend <= 1'b1;
            end else if (gnt_ecg) begin
                ecg_pend <= 1'b0;
            end

            // last_ecg only moves when both channels contend.
            if (emg_pend && ecg_pend)
                last_ecg <= gnt_ecg;

            adc_wEn <= gnt_any;
            if (gnt_any) begin
                adc_addr   <= wr_addr;
                adc_dataIn <= wr_data;
            end
            if (gnt_emg) emg_wptr <= emg_wptr + PTR_W'(1);
            if (gnt_ecg) ecg_wptr <= ecg_wptr + PTR_W'(1);

            // Events coinciding with clr land after the clear.
            if (emg_wrap_ev)  emg_wrap <= 1'b1;
            else if (clr)     emg_wrap <= 1'b0;
            if (ecg_wrap_ev)  ecg_wrap <= 1'b1;
            else if (clr)     ecg_wrap <= 1'b0;

            if (emg_ovr_ev)
                emg_ovr <= clr ? 8'd1 : ((emg_ovr == 8'hFF) ? 8'hFF : emg_ovr + 8'd1);
            else if (clr)
                emg_ovr <= '0;
            if (ecg_ovr_ev)
                ecg_ovr <= clr ? 8'd1 : ((ecg_ovr == 8'hFF) ? 8'hFF : ecg_ovr + 8'd1);
            else if (clr)
                ecg_ovr <= '0;
        end
    end

endmodule

// File: tb/tb_adc_ring_writer.sv
// Directed bench for adc_ring_writer: vector table plus hand-built multi-cycle sequences.
module tb_adc_ring_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable, clr;
    logic        emg_valid, ecg_valid;
    logic [31:0] emg_data, ecg_data;
    logic        adc_wEn;
    logic [11:0] adc_addr;
    logic [31:0] adc_dataIn;
    logic [5:0]  emg_wptr, ecg_wptr;
    logic        emg_wrap, ecg_wrap;
    logic [7:0]  emg_ovr, ecg_ovr;

    int n_chk  = 0;
    int n_fail = 0;

    adc_ring_writer dut (
        .clock(clock), .reset(reset), .enable(enable), .clr(clr),
        .emg_valid(emg_valid), .emg_data(emg_data),
        .ecg_valid(ecg_valid), .ecg_data(ecg_data),
        .adc_wEn(adc_wEn), .adc_addr(adc_addr), .adc_dataIn(adc_dataIn),
        .emg_wptr(emg_wptr), .ecg_wptr(ecg_wptr),
        .emg_wrap(emg_wrap), .ecg_wrap(ecg_wrap),
        .emg_ovr(emg_ovr), .ecg_ovr(ecg_ovr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ev;
        logic [31:0] ed;
        logic        cv;
        logic [31:0] cd;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
        logic [5:0]  ew;
        logic [5:0]  cw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; clr = 1'b0;
        emg_valid = 1'b0; ecg_valid = 1'b0;
        emg_data = '0; ecg_data = '0;
    endtask

    // Called 1 time unit after an edge, so the pulse never overlaps a rising edge.
    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    vec_t vt [18];

    initial begin
        idle_inputs();

        //           rst   en    ev    ed            cv    cd            wen   addr     data          ew  cw
        vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b0, 32'h0,        1'b0, 12'h000, 32'h0,        0, 0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hC00, 32'h0000_0ABC, 1, 0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 12'hC00, 32'h0000_0ABC, 1, 0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h111,       1'b1, 32'h222,      1'b0, 12'h000, 32'h0,        0, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hC00, 32'h111,      1, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hE00, 32'h222,      1, 1};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h333,       1'b1, 32'h444,      1'b0, 12'hE00, 32'h222,      1, 1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hE01, 32'h444,      1, 2};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hC01, 32'h333,      2, 2};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 12'hC01, 32'h333,      2, 2};
        vt[10] = '{1'b0, 1'b1, 1'b1, 32'h666,       1'b0, 32'h0,        1'b0, 12'hC01, 32'h333,      2, 2};
        vt[11] = '{1'b0, 1'b0, 1'b1, 32'h777,       1'b1, 32'h888,      1'b1, 12'hC02, 32'h666,      3, 2};
        vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 12'hC02, 32'h666,      3, 2};
        vt[13] = '{1'b0, 1'b0, 1'b1, 32'h999,       1'b0, 32'h0,        1'b0, 12'hC02, 32'h666,      3, 2};
        vt[14] = '{1'b0, 1'b1, 1'b1, 32'hAAA,       1'b0, 32'h0,        1'b0, 12'hC02, 32'h666,      3, 2};
        vt[15] = '{1'b0, 1'b1, 1'b1, 32'hBBB,       1'b0, 32'h0,        1'b1, 12'hC03, 32'hAAA,      4, 2};
        vt[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b1, 12'hC04, 32'hBBB,      5, 2};
        vt[17] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 12'hC04, 32'hBBB,      5, 2};

        // Reset state
        #2;
        chk("rst wEn",  32'(adc_wEn),    32'h0);
        chk("rst addr", 32'(adc_addr),   32'h0);
        chk("rst data", adc_dataIn,      32'h0);
        chk("rst ptrs", {16'h0, 2'b0, emg_wptr, 2'b0, ecg_wptr}, 32'h0);
        chk("rst flags", {14'h0, emg_wrap, ecg_wrap, emg_ovr, ecg_ovr}, 32'h0);
        reset = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rst) pulse_reset();
            enable    = vt[i].en;
            emg_valid = vt[i].ev; emg_data = vt[i].ed;
            ecg_valid = vt[i].cv; ecg_data = vt[i].cd;
            tick();
            chk($sformatf("vec%0d wEn", i),  32'(adc_wEn),  32'(vt[i].wen));
            chk($sformatf("vec%0d addr", i), 32'(adc_addr), 32'(vt[i].addr));
            chk($sformatf("vec%0d data", i), adc_dataIn,    vt[i].data);
            chk($sformatf("vec%0d ew", i),   32'(emg_wptr), 32'(vt[i].ew));
            chk($sformatf("vec%0d cw", i),   32'(ecg_wptr), 32'(vt[i].cw));
            chk($sformatf("vec%0d ovr", i),  {16'h0, emg_ovr, ecg_ovr}, 32'h0);
        end
        idle_inputs();

        // Both channels strobing every cycle for 10 edges
        pulse_reset();
        for (int n = 1; n <= 10; n++) begin
            emg_valid = 1'b1; emg_data = 32'h100 + 32'(n);
            ecg_valid = 1'b1; ecg_data = 32'h200 + 32'(n);
            tick();
            if (n == 1) begin
                chk("stream e1 wEn", 32'(adc_wEn), 32'h0);
            end else begin
                chk($sformatf("stream e%0d wEn", n), 32'(adc_wEn), 32'h1);
                if (n % 2 == 0) begin
                    chk($sformatf("stream e%0d addr", n), 32'(adc_addr), 32'hC00 + 32'((n - 2) / 2));
                    chk($sformatf("stream e%0d data", n), adc_dataIn, 32'h100 + 32'(n - 1));
                end else begin
                    chk($sformatf("stream e%0d addr", n), 32'(adc_addr), 32'hE00 + 32'((n - 3) / 2));
                    chk($sformatf("stream e%0d data", n), adc_dataIn, 32'h200 + 32'(n - 1));
                end
            end
        end
        chk("stream emg_ovr", 32'(emg_ovr), 32'd4);
        chk("stream ecg_ovr", 32'(ecg_ovr), 32'd5);
        chk("stream ew", 32'(emg_wptr), 32'd5);
        chk("stream cw", 32'(ecg_wptr), 32'd4);
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr emg_ovr", 32'(emg_ovr), 32'd0);
        chk("clr ecg_ovr", 32'(ecg_ovr), 32'd0);
        chk("drain ecg addr", 32'(adc_addr), 32'hE04);
        chk("drain ecg data", adc_dataIn, 32'h20A);
        tick();
        chk("drain emg addr", 32'(adc_addr), 32'hC05);
        chk("drain emg data", adc_dataIn, 32'h10A);
        tick();
        chk("drain idle wEn", 32'(adc_wEn), 32'h0);

        // Overrun coinciding with clr: the increment wins
        pulse_reset();
        emg_valid = 1'b1; ecg_valid = 1'b1; emg_data = 32'h1; ecg_data = 32'h2;
        tick();
        clr = 1'b1;
        tick();
        idle_inputs();
        chk("clr+ovr ecg_ovr", 32'(ecg_ovr), 32'd1);
        chk("clr+ovr emg_ovr", 32'(emg_ovr), 32'd0);

        // 65 EMG strobes spaced 3 cycles apart: wrap boundary
        pulse_reset();
        for (int j = 0; j <= 64; j++) begin
            emg_valid = 1'b1; emg_data = 32'hD000 + 32'(j);
            tick();
            emg_valid = 1'b0;
            tick();
            chk($sformatf("wrap w%0d wEn", j),  32'(adc_wEn), 32'h1);
            chk($sformatf("wrap w%0d addr", j), 32'(adc_addr), 32'hC00 + 32'(j % 64));
            chk($sformatf("wrap w%0d data", j), adc_dataIn, 32'hD000 + 32'(j));
            if (j == 62) chk("wrap pre flag", 32'(emg_wrap), 32'h0);
            if (j == 63) begin
                chk("wrap ptr0", 32'(emg_wptr), 32'h0);
                chk("wrap flag", 32'(emg_wrap), 32'h1);
            end
            if (j == 64) begin
                chk("wrap ptr1", 32'(emg_wptr), 32'h1);
                chk("wrap sticky", 32'(emg_wrap), 32'h1);
            end
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("wrap clr flag", 32'(emg_wrap), 32'h0);
        chk("wrap clr ptr kept", 32'(emg_wptr), 32'h1);

        // Asynchronous reset with both channels pending
        pulse_reset();
        emg_valid = 1'b1; ecg_valid = 1'b1; emg_data = 32'h11; ecg_data = 32'h22;
        tick();
        ecg_valid = 1'b0; emg_data = 32'h33;
        tick();
        idle_inputs();
        chk("mid wEn before rst", 32'(adc_wEn), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid rst wEn", 32'(adc_wEn), 32'h0);
        chk("mid rst ptrs", {16'h0, 2'b0, emg_wptr, 2'b0, ecg_wptr}, 32'h0);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post rst idle%0d", k), 32'(adc_wEn), 32'h0);
        end
        emg_valid = 1'b1; emg_data = 32'h5A5A;
        tick();
        idle_inputs();
        tick();
        chk("post rst wEn", 32'(adc_wEn), 32'h1);
        chk("post rst addr", 32'(adc_addr), 32'hC00);
        chk("post rst data", adc_dataIn, 32'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ring_writer.md
Name: adc_ring_writer

Overview:
- Owns the RAM's write-only ADC port; shares it between the EMG and ECG capture channels.
- Each channel gets its own circular buffer region in data memory.
- Accepts one-cycle sample strobes from the ADC capture block and holds one pending sample per channel.
- Round-robin arbitrates a single write per cycle, and exposes write pointers, wrap flags and overrun counters so software can poll the buffers.

Parameters:
- EMG_BASE, 12'hC00, first word address of EMG ring
- ECG_BASE, 12'hE00, first word address of ECG ring
- DEPTH, 64, words per ring; power of two, 2..512; BASE+DEPTH ≤ 4096
- PTR_W, 6, log2(DEPTH)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- enable  in  1  1 = accept new samples; 0 = ignore strobes, drain pending
- clr  in  1  synchronous one-cycle pulse: clear wrap flags and overrun counters
- emg_valid  in  1  one-cycle strobe, emg_data valid
- emg_data  in  32  EMG sample
- ecg_valid  in  1  one-cycle strobe, ecg_data valid
- ecg_data  in  32  ECG sample
- adc_wEn  out  1  RAM ADC-port write enable
- adc_addr  out  12  RAM ADC-port word address
- adc_dataIn  out  32  RAM ADC-port write data
- emg_wptr  out  PTR_W  next EMG slot to be written
- ecg_wptr  out  PTR_W  next ECG slot to be written
- emg_wrap  out  1  sticky: EMG pointer has wrapped
- ecg_wrap  out  1  sticky: ECG pointer has wrapped
- emg_ovr  out  8  EMG overrun count, saturating at 255
- ecg_ovr  out  8  ECG overrun count, saturating at 255

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Pending flags 0.
  - last_grant = ECG, so EMG wins the first tie.
- Capture, per channel, at the rising edge:
  - If enable=1 and valid=1, the data is latched into the holding register and pending is set.
- Arbitration: at each edge, only pending flags held *before* that edge compete.
  - One pending: it is granted.
  - Both pending: grant the channel != last_grant; last_grant updates to the winner.
  - None pending: adc_wEn=0 next cycle; adc_addr and adc_dataIn hold their last value.
- Grant: on the same edge, registered outputs load:
  - adc_wEn=1.
  - adc_addr = BASE + wptr (zero-extended).
  - adc_dataIn = held data.
  - The channel's wptr increments; it wraps DEPTH-1→0, and wrap is set on the wrap.
  - The channel's pending clears unless a new strobe arrives on that edge.
- Latency: strobe at edge k → pending after k → adc_wEn=1 during cycle after edge k+1 → RAM writes at edge k+2. If the other channel wins the tie, add one cycle.
- Throughput: at most one write per cycle. Both channels strobing every cycle alternate, each overrunning every other sample.
- Overrun:
  - Condition: strobe (enable=1) while pending=1 and that channel not granted on the same edge.
  - Effect: new data overwrites the held data (newest kept) and ovr increments, saturating at 255.
- Strobe on the same edge the channel is granted: the old data is written, the new data becomes pending, no overrun.
- enable=0: strobes ignored, no overrun counted; pending samples still drain normally.
- clr=1: wrap and ovr cleared. If a wrap or overrun coincides with clr, the event wins (set/increment applies after the clear). Pointers are unaffected.
- Mid-operation reset: pending samples discarded, pointers to 0, adc_wEn drops immediately (asynchronous).

Optional Feature:
- Macro ADC_RING_TAG_EN.
- Defined: adc_dataIn[31:28] is replaced by {channel (0=EMG, 1=ECG), wptr[2:0] of the slot being written}; bits [27:0] are the sample. Software can then detect stale slots.
- Undefined: adc_dataIn is the full 32-bit sample, unmodified.

Test Plan:
- After reset, single emg_valid with data 32'h0000_0ABC:
  - two edges later adc_wEn=1, adc_addr=12'hC00, adc_dataIn=32'h0000_0ABC; emg_wptr=1.
- emg_valid and ecg_valid on the same edge:
  - EMG written at 12'hC00 first, then ECG at 12'hE00 the next cycle.
  - Repeat both together: ECG is written first.
- 64 EMG strobes spaced 3 cycles apart:
  - the 64th write goes to 12'hC3F; emg_wptr=0; emg_wrap=1.
  - The 65th write goes to 12'hC00.
- Both channels strobing every cycle for 10 cycles:
  - writes alternate; emg_ovr and ecg_ovr each reach 4 or 5 (check exact value against the model).
  - A clr pulse then zeroes both counters.
- Strobes with enable=0:
  - no adc_wEn, counters and pointers unchanged.
  - A pending sample captured before enable fell is still written.
- reset pulled low while EMG and ECG are both pending:
  - adc_wEn=0 immediately, pointers 0.
  - No write occurs after reset releases until a new strobe.
